add_share_arb: RTL and testbench

ADD_SHARE_ARB -- requirements
Module: add_share_arb

---
 rtl/add_pkg.sv | 15 +
 rtl/add_nbit.sv | 16 +
 rtl/add_share_arb.sv | 156 +++++++++++++++
 tb/tb_add_share_arb.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the shared-adder arbiter: FSM states, default
// operand/requester counts and the requester-id width.
package add_pkg;

  localparam int unsigned N_DEFAULT    = 8;
  localparam int unsigned NREQ_DEFAULT = 4;
  localparam int unsigned ID_W         = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/add_nbit.sv
// Exact signed adder: two N-bit two's-complement operands, N+1-bit sum.
// Ports:
//   a_i, b_i : signed N-bit operands
//   sum_o    : signed N+1-bit exact sum
module add_nbit #(
  parameter int unsigned N = 8
) (
  input  logic signed [N-1:0] a_i,
  input  logic signed [N-1:0] b_i,
  output logic signed [N:0]   sum_o
);

  // Sign-extend both operands by one bit so the sum can never wrap.
  assign sum_o = {a_i[N-1], a_i} + {b_i[N-1], b_i};

endmodule

// File: rtl/add_share_arb.sv
// One shared signed adder time-multiplexed between NREQ requesters with a
// round-robin grant and a single registered response channel.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake (ready is combinational)
//   req_a, req_b        : packed signed operands, requester i at [i*N +: N]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id              : owning requester of the response
//   rsp_sum, rsp_ovf    : exact N+1-bit sum and N-bit signed overflow flag
module add_share_arb
  import add_pkg::*;
#(
  parameter int unsigned N    = N_DEFAULT,
  parameter int unsigned NREQ = NREQ_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*N-1:0]      req_a,
  input  logic [NREQ*N-1:0]      req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic signed [N:0]      rsp_sum,
  output logic                   rsp_ovf
);

  state_e                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       g_q, g_d;
  logic signed [N-1:0]   a_q, a_d;
  logic signed [N-1:0]   b_q, b_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic signed [N:0]     rsp_sum_q, rsp_sum_d;
  logic                  rsp_ovf_q, rsp_ovf_d;

  logic                  grant_found;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W-1:0]       cand;
  logic [N-1:0]          sel_a, sel_b;
  logic signed [N:0]     sum_w;
  logic                  accept;

  // Rotated priority search: first valid requester starting at ptr+1.
  // The ID_W-bit add wraps naturally because NREQ == 2**ID_W.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = ptr_q + ID_W'(k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        sel_a = req_a[i*N +: N];
        sel_b = req_b[i*N +: N];
      end
    end
  end

  // Ready only in IDLE, only for the grant, and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);

  add_nbit #(.N(N)) u_add (
    .a_i   (a_q),
    .b_i   (b_q),
    .sum_o (sum_w)
  );

  // Next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_ovf_d   = rsp_ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = sel_a;
          b_d     = sel_b;
          g_d     = grant_idx;
          state_d = ADD;
        end
      end
      ADD: begin
        rsp_sum_d   = sum_w;
        rsp_ovf_d   = sum_w[N] ^ sum_w[N-1];
        rsp_id_d    = g_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          ptr_d       = rsp_id_q;
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(NREQ - 1);
      g_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_ovf_q   <= rsp_ovf_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_add_share_arb.sv
// Self-checking bench for add_share_arb with a round-robin/arithmetic model.
module tb_add_share_arb;

  logic              clk;
  logic              rst_n;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [31:0]       req_a;
  logic [31:0]       req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic signed [8:0] rsp_sum;
  logic              rsp_ovf;

  int n_checks;
  int n_fail;
  int ptr_m;

  add_share_arb #(.N(8), .NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ovf   (rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int i, input int a, input int b);
    req_a[i*8 +: 8] = a[7:0];
    req_b[i*8 +: 8] = b[7:0];
  endtask

  // One full transaction from the current IDLE negedge, checked against the model.
  task automatic do_txn(input int stall);
    int pred, waitc, s;
    logic signed [7:0] ea, eb;
    logic signed [8:0] esum;
    logic eovf;
    logic [3:0] exp_rdy;
    pred = -1;
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (ptr_m + k) % 4;
      if (pred < 0 && req_valid[i]) pred = i;
    end
    rsp_ready = 1'b0;
    #1;
    waitc = 0;
    while (req_ready == 4'b0 && waitc < 8) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    n_checks++;
    if (req_ready == 4'b0) begin
      n_fail++;
      $display("FAIL grant_timeout: req_ready=%b valid=%b", req_ready, req_valid);
      return;
    end
    exp_rdy = 4'b0001 << pred;
    n_checks++;
    if (req_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_rdy);
    end
    ea = req_a[pred*8 +: 8];
    eb = req_b[pred*8 +: 8];
    s = int'(ea) + int'(eb);
    esum = s[8:0];
    eovf = (s > 127) || (s < -128);
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0) begin
      n_fail++;
      $display("FAIL add_phase: rsp_valid=%b req_ready=%b expected 0/0000", rsp_valid, req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== esum || rsp_id !== 2'(pred) || rsp_ovf !== eovf) begin
      n_fail++;
      $display("FAIL resp: valid=%b sum=%0d id=%0d ovf=%b expected 1/%0d/%0d/%b",
               rsp_valid, rsp_sum, rsp_id, rsp_ovf, esum, pred, eovf);
    end
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== esum || rsp_id !== 2'(pred) ||
          rsp_ovf !== eovf || req_ready !== 4'b0) begin
        n_fail++;
        $display("FAIL stall_hold: valid=%b sum=%0d id=%0d ovf=%b rdy=%b expected 1/%0d/%0d/%b/0000",
                 rsp_valid, rsp_sum, rsp_id, rsp_ovf, req_ready, esum, pred, eovf);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_drop: rsp_valid=%b expected 0", rsp_valid);
    end
    ptr_m = pred;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    req_a = 32'h0;
    req_b = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || rsp_sum !== 9'sd0 ||
        rsp_id !== 2'd0 || rsp_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b valid=%b sum=%0d id=%0d ovf=%b expected all zero",
               req_ready, rsp_valid, rsp_sum, rsp_id, rsp_ovf);
    end
    req_valid = 4'h0;
    rst_n = 1'b1;
    ptr_m = 3;
  endtask

  task automatic test_basic();
    req_valid = 4'b0001;
    set_req(0, 5, 3);
    do_txn(0);
    req_valid = 4'b0000;
  endtask

  task automatic test_all_valid();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 3;
    for (int i = 0; i < 4; i++) set_req(i, 10 * i + 1, -3 * i - 7);
    req_valid = 4'hF;
    for (int n = 0; n < 4; n++) begin
      do_txn(0);
      req_valid[ptr_m] = 1'b0;
    end
    req_valid = 4'h0;
  endtask

  task automatic test_ovf();
    req_valid = 4'b0100;
    set_req(2, 127, 1);
    do_txn(0);
    set_req(2, -128, -1);
    do_txn(0);
    set_req(2, -10, -20);
    do_txn(0);
    req_valid = 4'b0000;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) set_req(i, 40 - i, 60 + i);
    req_valid = 4'hF;
    do_txn(5);
    req_valid = 4'h0;
  endtask

  task automatic test_back_to_back();
    int acc, vcnt;
    acc = 0;
    vcnt = 0;
    for (int i = 0; i < 4; i++) set_req(i, i, i);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (|(req_valid & req_ready)) acc++;
      if (rsp_valid) vcnt++;
      @(negedge clk);
    end
    req_valid = 4'h0;
    rsp_ready = 1'b0;
    n_checks++;
    if (acc != 4 || vcnt != 4) begin
      n_fail++;
      $display("FAIL back_to_back: accepts=%0d resp_cycles=%0d expected 4/4", acc, vcnt);
    end
  endtask

  task automatic test_reset_in_add();
    int waitc;
    req_valid = 4'b0001;
    set_req(0, 50, 70);
    rsp_ready = 1'b1;
    #1;
    waitc = 0;
    while (req_ready[0] !== 1'b1 && waitc < 8) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_in_add: valid=%b rdy=%b expected 0/0000", rsp_valid, req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b0000;
    ptr_m = 3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL discard_inflight: rsp_valid=%b expected 0", rsp_valid);
      end
    end
    rsp_ready = 1'b0;
    for (int i = 1; i < 4; i++) set_req(i, -i, 9 * i);
    set_req(0, 50, 70);
    req_valid = 4'hF;
    do_txn(0);
    req_valid = 4'h0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      req_valid = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) set_req(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      do_txn(int'($urandom_range(0, 2)));
    end
    req_valid = 4'h0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    ptr_m = 3;
    test_reset();
    @(negedge clk);
    test_basic();
    test_ovf();
    test_all_valid();
    test_stall();
    test_back_to_back();
    test_reset_in_add();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
